// File: rtl/bcd_counter_display_pkg.sv
// Shared constants for the BCD counter / 7-segment display block.
// Holds the BCD digit width, the active-low segment patterns {g,f,e,d,c,b,a},
// and the per-digit increment/decrement helpers used by the counter chain.
package bcd_counter_display_pkg;

   localparam int BCD_W      = 4;
   localparam int NUM_DIGITS = 4;

   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Next value of one BCD digit given the carry/borrow coming into it.
   function automatic logic [BCD_W-1:0] bcd_digit_next(
      input logic [BCD_W-1:0] d,
      input logic             up_dir,
      input logic             cin
   );
      logic [BCD_W-1:0] r;
      r = d;
      if (cin) begin
         if (up_dir) r = (d >= BCD_MAX) ? '0 : d + 1'b1;
         else        r = (d == '0) ? BCD_MAX : d - 1'b1;
      end
      return r;
   endfunction

   // True when this digit rolls over (9->0 up, 0->9 down) and must
   // propagate a carry/borrow into the next digit.
   function automatic logic bcd_digit_wraps(
      input logic [BCD_W-1:0] d,
      input logic             up_dir
   );
      return up_dir ? (d >= BCD_MAX) : (d == '0);
   endfunction

endpackage

// File: rtl/bcd_counter_display_seg7_decoder.sv
// seg7_decoder: BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Purely combinational, zero latency; no flow control.
// Ports: i_digit (4-bit BCD in), o_seg (7-bit active-low segments; blank on non-BCD input).
module seg7_decoder
   import bcd_counter_display_pkg::*;
(
   input  logic [BCD_W-1:0] i_digit,
   output logic [6:0]       o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_digit)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_counter_display.sv
// bcd_counter_display: 4-digit up/down BCD counter stepped by rising edges of
// tick_in, with a time-multiplexed active-low 7-segment display driver.
// Latency: count updates on the clk edge that samples the tick_in rise; display is combinational.
// No backpressure: every detected rise is consumed (or dropped when en=0).
// Ports: clk, rst (async, active-high), tick_in (divided square wave, data only),
//        en (count enable), up (1=inc, 0=dec), clr (sync clear, beats step),
//        count[15:0] (BCD, [3:0]=ones), step (rise pulse), an[3:0], seg[6:0], dp.
module bcd_counter_display
   import bcd_counter_display_pkg::*;
#(
   parameter int REFRESH_BITS = 17
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_in,
   input  logic        en,
   input  logic        up,
   input  logic        clr,
   output logic [15:0] count,
   output logic        step,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   logic                    r_tick_d;
   logic [15:0]             r_count;
   logic [REFRESH_BITS-1:0] r_refresh;

   logic                    w_c1;
   logic                    w_c2;
   logic                    w_c3;
   logic [15:0]             w_count_nxt;
   logic [1:0]              w_sel;
   logic [BCD_W-1:0]        w_digit;

   // Rising-edge detect on the divider output; tick_in is never used as a clock.
   assign step = tick_in & ~r_tick_d;

   // Ripple carry/borrow: a digit moves only if every lower digit wraps.
   assign w_c1 = bcd_digit_wraps(r_count[3:0], up);
   assign w_c2 = w_c1 & bcd_digit_wraps(r_count[7:4], up);
   assign w_c3 = w_c2 & bcd_digit_wraps(r_count[11:8], up);

   assign w_count_nxt = {
      bcd_digit_next(r_count[15:12], up, w_c3),
      bcd_digit_next(r_count[11:8],  up, w_c2),
      bcd_digit_next(r_count[7:4],   up, w_c1),
      bcd_digit_next(r_count[3:0],   up, 1'b1)
   };

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick_d  <= 1'b0;
         r_count   <= '0;
         r_refresh <= '0;
      end else begin
         r_tick_d  <= tick_in;
         r_refresh <= r_refresh + 1'b1;
         if (clr)              r_count <= '0;
         else if (step && en)  r_count <= w_count_nxt;
      end
   end

   assign count = r_count;
   assign dp    = 1'b1;

   // Top two refresh bits pick the digit being driven.
   assign w_sel = r_refresh[REFRESH_BITS-1 -: 2];

   always_comb begin
      an      = 4'b1110;
      w_digit = r_count[3:0];
      case (w_sel)
         2'd1: begin
            an      = 4'b1101;
            w_digit = r_count[7:4];
         end
         2'd2: begin
            an      = 4'b1011;
            w_digit = r_count[11:8];
         end
         2'd3: begin
            an      = 4'b0111;
            w_digit = r_count[15:12];
         end
         default: begin
            an      = 4'b1110;
            w_digit = r_count[3:0];
         end
      endcase
   end

   seg7_decoder u_seg7_decoder (
      .i_digit (w_digit),
      .o_seg   (seg)
   );

endmodule

// File: doc/bcd_counter_display.md
BCD_COUNTER_DISPLAY -- requirements
Module: bcd_counter_display

Interface
REQ-001 The block SHALL have parameter REFRESH_BITS, default 17, giving the width of the display refresh counter (about 763 Hz digit rate at 100 MHz).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port tick_in, input, 1 bit: the divided square wave from the upstream clock divider, synchronous to clk, used as data and never as a clock.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous clear of the count.
REQ-008 The block SHALL have port count, output, 16 bits: four BCD digits, with [3:0] as ones and [15:12] as thousands.
REQ-009 The block SHALL have port step, output, 1 bit: one-cycle pulse on each detected tick_in rising edge.
REQ-010 The block SHALL have port an, output, 4 bits: active-low digit anodes.
REQ-011 The block SHALL have port seg, output, 7 bits: active-low segments in order {g,f,e,d,c,b,a}.
REQ-012 The block SHALL have port dp, output, 1 bit: decimal point, held at 1 (off).

Function
REQ-013 The block SHALL hold a tick_d register that captures tick_in every cycle.
- step = tick_in & ~tick_d (combinational from the registered state).
REQ-014 When step=1, en=1 and clr=0 at a clk edge, count SHALL advance by one BCD unit at that edge.
- The edge at which tick_in first samples 1 therefore updates count one cycle after the divider toggles.
REQ-015 Up counting SHALL use per-digit BCD carry.
- A digit at 9 wraps to 0 and carries into the next digit.
- 9999 wraps to 0000.
REQ-016 Down counting SHALL use per-digit BCD borrow.
- A digit at 0 wraps to 9 and borrows from the next digit.
- 0000 wraps to 9999.
REQ-017 clr=1 SHALL force count to 0000 at the next edge, with priority over any simultaneous step.
REQ-018 en=0 SHALL hold count, while tick_d and step continue to track tick_in.
REQ-019 A falling edge of tick_in, or tick_in held steady, SHALL produce no step.
REQ-020 The up input SHALL be sampled only at step edges; changing up between steps has no other effect.
REQ-021 The refresh counter SHALL be REFRESH_BITS wide and free-run by +1 every cycle, wrapping at all-ones.
- sel = its top 2 bits.
REQ-022 an SHALL be one-hot low according to sel:
- sel 0 gives an=1110, showing count[3:0].
- sel 1 gives an=1101, showing count[7:4].
- sel 2 gives an=1011, showing count[11:8].
- sel 3 gives an=0111, showing count[15:12].
REQ-023 seg SHALL be the active-low 7-segment code of the selected digit.
- Digit 0 = 1000000, 1 = 1111001, 8 = 0000000, 9 = 0010000.
- seg is combinational from count and sel.
REQ-024 The block SHALL assume count digits are always in 0-9; if any other value reaches the decoder, seg SHALL be 1111111 (blank).

Reset
REQ-025 rst=1 SHALL immediately, without waiting for clk, force count=0000, tick_d=0 and refresh counter=0.
- Resulting outputs: an=1110, seg=1000000, step=tick_in, dp=1.
REQ-026 Reset asserted mid-count SHALL discard the count, with no step credited on release unless tick_in rises afterwards.
- If tick_in=1 at release, a step occurs on the first edge after release.

Structure
REQ-027 The shared package SHALL hold the seven-segment pattern constants and the BCD digit width constant (4).
REQ-028 Exactly one sub-module, seg7_decoder, SHALL be used: a 4-bit BCD input and a 7-bit active-low segment output, purely combinational.
REQ-029 The 4-digit counter SHALL be implemented in the top level with per-digit carry/borrow chain logic, not as a binary counter plus conversion.

Verification
REQ-030 The bench SHALL use REFRESH_BITS=4 and cover the following directed scenarios.
REQ-031 Up count: reset, then en=1, up=1 and 12 rising edges of tick_in. Required: count=0x0012 and exactly 12 step pulses.
REQ-032 Up wrap: preload to 9999 by stepping down once from 0000, then up=1 and one step. Required: first count=0x9999, then count=0x0000.
REQ-033 Carry chain: count at 0x0099, then one up step. Required: count=0x0100. Then one down step. Required: count=0x0099.
REQ-034 Clear priority: clr=1 on the same edge as a step with count=0x0456. Required: count=0x0000 next cycle. Also en=0 with 5 ticks: count unchanged, 5 step pulses.
REQ-035 Mid-operation reset: rst asserted between clk edges with count=0x0037. Required: count=0x0000 and an=1110 before the next clk edge.
REQ-036 Scan: count=0x1234 with the refresh counter running. Required: an cycles 1110, 1101, 1011, 0111, each for 4 cycles, with seg = codes for 4, 3, 2, 1 respectively.
